irq_ack_controller: RTL

- Sits directly downstream of the 4-source priority encoder and consumes its IRQ pulse and 2-bit source id.
- Latches events into a pending register and applies a per-source mask.
- Presents one interrupt at a time to the CPU core with a vector address, using a request/acknowledge/end-of-interrupt handshake.
- Provides the sequential bookkeeping that the combinational encoder lacks: edge capture, pending/in-service state and CPU handshake.

---
 rtl/irq_ack_controller_if.sv | 31 +++
 rtl/irq_ack_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/irq_ack_controller_if.sv
// Signal bundle between the IRQ encoder/CPU side and irq_ack_controller.
// slave = controller view, master = driver view (encoder + CPU).
interface irq_ack_controller_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned ADDR_W  = 32
);
  logic                irq_valid_i;
  logic [ID_W-1:0]     irq_id_i;
  logic                mask_we_i;
  logic [NUM_SRC-1:0]  mask_wdata_i;
  logic                cpu_ack_i;
  logic                cpu_eoi_i;
  logic                intr_req_o;
  logic [ID_W-1:0]     intr_id_o;
  logic [ADDR_W-1:0]   intr_vec_o;
  logic [NUM_SRC-1:0]  pending_o;
  logic [NUM_SRC-1:0]  mask_o;
  logic                in_service_o;
  logic                timeout_o;

  modport slave (
    input  irq_valid_i, irq_id_i, mask_we_i, mask_wdata_i, cpu_ack_i, cpu_eoi_i,
    output intr_req_o, intr_id_o, intr_vec_o, pending_o, mask_o, in_service_o, timeout_o
  );

  modport master (
    output irq_valid_i, irq_id_i, mask_we_i, mask_wdata_i, cpu_ack_i, cpu_eoi_i,
    input  intr_req_o, intr_id_o, intr_vec_o, pending_o, mask_o, in_service_o, timeout_o
  );
endinterface

// File: rtl/irq_ack_controller.sv
// Interrupt pending/mask/in-service bookkeeping with CPU req/ack/eoi handshake.
// Optional ack timeout enabled by defining IRQ_TIMEOUT_EN.
module irq_ack_controller #(
  parameter int unsigned       NUM_SRC        = 4,
  parameter int unsigned       ID_W           = 2,
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE       = ADDR_W'(32'h0000_0100),
  parameter int unsigned       VEC_STRIDE     = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irq_ack_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  if (NUM_SRC != (1 << ID_W) || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("irq_ack_controller: NUM_SRC must be 2**ID_W and TIMEOUT_CYCLES nonzero");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_valid_q;
  logic [NUM_SRC-1:0]  r_pending;
  logic [NUM_SRC-1:0]  r_mask;
  logic [ID_W-1:0]     r_intr_id;
  logic [ADDR_W-1:0]   r_vec;
  logic                r_intr_req;
  logic                r_in_service;
  logic                r_timeout;

  logic [NUM_SRC-1:0]  w_elig;
  logic                w_any;
  logic [ID_W-1:0]     w_sel_id;
  logic [NUM_SRC-1:0]  w_set;
  logic [NUM_SRC-1:0]  w_clr;
  logic                w_ack_take;
  logic                w_tmo_hit;
  logic                w_tmo_fire;
  logic                w_req_nxt;
  logic                w_svc_nxt;
  logic                w_id_load;

  // Edge capture and lowest-index selection among unmasked pending sources
  always_comb begin
    w_set    = '0;
    w_clr    = '0;
    w_sel_id = '0;
    w_elig   = r_pending & ~r_mask;
    w_any    = |w_elig;
    if (bus.irq_valid_i && !r_valid_q) begin
      w_set = NUM_SRC'(1) << bus.irq_id_i;
    end
    if (w_ack_take) begin
      w_clr = NUM_SRC'(1) << r_intr_id;
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel_id = ID_W'(i);
    end
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counts REQ cycles; held at zero whenever the request is not outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != S_REQ) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_tmo_hit = (r_state == S_REQ) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state logic; ack takes precedence over withdraw and timeout
  always_comb begin
    w_state_nxt = r_state;
    w_ack_take  = 1'b0;
    w_tmo_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.cpu_ack_i) begin
          w_state_nxt = S_SERVICE;
          w_ack_take  = 1'b1;
        end else if (r_mask[r_intr_id]) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_tmo_fire  = 1'b1;
        end
      end
      S_SERVICE: begin
        if (bus.cpu_eoi_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the next state, registered below
  always_comb begin
    w_req_nxt = 1'b0;
    w_svc_nxt = 1'b0;
    w_id_load = 1'b0;
    if (w_state_nxt == S_REQ)     w_req_nxt = 1'b1;
    if (w_state_nxt == S_SERVICE) w_svc_nxt = 1'b1;
    if (r_state == S_IDLE && w_any) w_id_load = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid_q    <= 1'b0;
      r_pending    <= '0;
      r_mask       <= '0;
      r_intr_id    <= '0;
      r_vec        <= VEC_BASE;
      r_intr_req   <= 1'b0;
      r_in_service <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_valid_q    <= bus.irq_valid_i;
      // A same-cycle set beats the ack clear so a new event is not lost
      r_pending    <= (r_pending & ~w_clr) | w_set;
      r_intr_req   <= w_req_nxt;
      r_in_service <= w_svc_nxt;
      if (bus.mask_we_i) r_mask <= bus.mask_wdata_i;
      if (w_id_load) begin
        r_intr_id <= w_sel_id;
        r_vec     <= VEC_BASE + ADDR_W'(w_sel_id) * ADDR_W'(VEC_STRIDE);
      end
      if (w_tmo_fire) r_timeout <= 1'b1;
    end
  end

  assign bus.intr_req_o   = r_intr_req;
  assign bus.intr_id_o    = r_intr_id;
  assign bus.intr_vec_o   = r_vec;
  assign bus.pending_o    = r_pending;
  assign bus.mask_o       = r_mask;
  assign bus.in_service_o = r_in_service;
  assign bus.timeout_o    = r_timeout;

endmodule
